rf_writeback: RTL and testbench



---
 rtl/rf_writeback.sv | 126 ++++++++++++
 tb/tb_rf_writeback.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/rf_writeback.sv
// Writeback sequencer for the 32x32 register file write port: ALU results win every slot,
// long-latency results are buffered in a small FIFO and drained into free slots.
module rf_writeback #(
  parameter int DEPTH = 4,
  parameter int DW    = 32,
  parameter int AW    = 5
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     alu_valid_i,
  input  logic [AW-1:0]            alu_adr_i,
  input  logic [DW-1:0]            alu_data_i,
  input  logic                     lu_valid_i,
  output logic                     lu_ready_o,
  input  logic [AW-1:0]            lu_adr_i,
  input  logic [DW-1:0]            lu_data_i,
  output logic [AW-1:0]            wadr_o,
  output logic [DW-1:0]            wdata_o,
  output logic [31:0]              pend_mask_o,
  output logic [$clog2(DEPTH):0]   fifo_count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0]    q_adr  [DEPTH];
  logic [DW-1:0]    q_data [DEPTH];
  logic [DEPTH-1:0] q_live;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    count;

  logic          alu_win;
  logic          fifo_empty;
  logic          lu_xfer;
  logic          lu_nonzero;
  logic          bypass;
  logic          push;
  logic          push_live;
  logic          pop;
  logic [AW-1:0] wadr_nxt;
  logic [DW-1:0] wdata_nxt;

  assign alu_win    = alu_valid_i && (alu_adr_i != '0);
  assign fifo_empty = (count == '0);
  assign lu_ready_o = !rst_i && (count < CW'(DEPTH));
  assign lu_xfer    = lu_valid_i && lu_ready_o;
  assign lu_nonzero = (lu_adr_i != '0);

  // Bypass only when the slot is free and nothing older is queued, so ordering holds.
  assign bypass    = !alu_win && fifo_empty && lu_xfer && lu_nonzero;
  assign push      = lu_xfer && lu_nonzero && !bypass;
  assign push_live = !(alu_win && (lu_adr_i == alu_adr_i));
  assign pop       = !alu_win && !fifo_empty;

  always_comb begin
    wadr_nxt  = '0;
    wdata_nxt = '0;
    if (alu_win) begin
      wadr_nxt  = alu_adr_i;
      wdata_nxt = alu_data_i;
    end else if (!fifo_empty) begin
      // A dead head still burns the slot as a harmless r0 write.
      if (q_live[rd_ptr]) begin
        wadr_nxt  = q_adr[rd_ptr];
        wdata_nxt = q_data[rd_ptr];
      end
    end else if (bypass) begin
      wadr_nxt  = lu_adr_i;
      wdata_nxt = lu_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      q_adr[wr_ptr]  <= lu_adr_i;
      q_data[wr_ptr] <= lu_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_live  <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      wadr_o  <= '0;
      wdata_o <= '0;
    end else begin
      wadr_o  <= wadr_nxt;
      wdata_o <= wdata_nxt;
      // The live bit doubles as occupancy for the pending mask, so a pop clears it too.
      for (int i = 0; i < DEPTH; i++) begin
        if (alu_win && (q_adr[i] == alu_adr_i)) begin
          q_live[i] <= 1'b0;
        end
      end
      if (pop) begin
        q_live[rd_ptr] <= 1'b0;
        rd_ptr         <= rd_ptr + 1'b1;
      end
      if (push) begin
        q_live[wr_ptr] <= push_live;
        wr_ptr         <= wr_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    pend_mask_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (q_live[i]) begin
        pend_mask_o[q_adr[i]] = 1'b1;
      end
    end
    pend_mask_o[0] = 1'b0;
  end

  assign fifo_count_o = count;

endmodule

// File: tb/tb_rf_writeback.sv
// Directed bench for rf_writeback: a queue-based reference model checked every cycle,
// plus literal expectations for each scenario.
module tb_rf_writeback;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        alu_valid_i;
  logic [4:0]  alu_adr_i;
  logic [31:0] alu_data_i;
  logic        lu_valid_i;
  logic        lu_ready_o;
  logic [4:0]  lu_adr_i;
  logic [31:0] lu_data_i;
  logic [4:0]  wadr_o;
  logic [31:0] wdata_o;
  logic [31:0] pend_mask_o;
  logic [2:0]  fifo_count_o;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  rf_writeback #(.DEPTH(4), .DW(32), .AW(5)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .alu_valid_i(alu_valid_i), .alu_adr_i(alu_adr_i), .alu_data_i(alu_data_i),
    .lu_valid_i(lu_valid_i), .lu_ready_o(lu_ready_o), .lu_adr_i(lu_adr_i), .lu_data_i(lu_data_i),
    .wadr_o(wadr_o), .wdata_o(wdata_o), .pend_mask_o(pend_mask_o), .fifo_count_o(fifo_count_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { logic [4:0] adr; logic [31:0] data; bit live; } ent_t;
  ent_t        mq[$];
  logic [4:0]  m_wadr;
  logic [31:0] m_wdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a write slot per cycle, ALU first, then queue head, then bypass.
  always @(posedge clk_i) begin
    bit   xfer;
    ent_t h;
    if (rst_i) begin
      mq.delete();
      m_wadr  = 0;
      m_wdata = 0;
    end else begin
      xfer    = lu_valid_i && (mq.size() < 4);
      m_wadr  = 0;
      m_wdata = 0;
      if (alu_valid_i && alu_adr_i != 0) begin
        m_wadr  = alu_adr_i;
        m_wdata = alu_data_i;
        foreach (mq[i]) if (mq[i].adr == alu_adr_i) mq[i].live = 0;
        if (xfer && lu_adr_i != 0) mq.push_back('{lu_adr_i, lu_data_i, lu_adr_i != alu_adr_i});
      end else if (mq.size() > 0) begin
        h = mq.pop_front();
        if (h.live) begin
          m_wadr  = h.adr;
          m_wdata = h.data;
        end
        if (xfer && lu_adr_i != 0) mq.push_back('{lu_adr_i, lu_data_i, 1'b1});
      end else if (xfer && lu_adr_i != 0) begin
        m_wadr  = lu_adr_i;
        m_wdata = lu_data_i;
      end
    end
  end

  always @(negedge clk_i) begin
    logic [31:0] m_pend;
    if (chk_en) begin
      m_pend = 0;
      foreach (mq[i]) if (mq[i].live) m_pend |= 32'h1 << mq[i].adr;
      chk("model_wadr",  {27'd0, wadr_o}, {27'd0, m_wadr});
      chk("model_wdata", wdata_o, m_wdata);
      chk("model_count", {29'd0, fifo_count_o}, mq.size());
      chk("model_ready", {31'd0, lu_ready_o}, {31'd0, (!rst_i && mq.size() < 4)});
      chk("model_pend",  pend_mask_o, m_pend);
    end
  end

  task automatic step(input bit r, input bit av, input logic [4:0] aa, input logic [31:0] ad,
                      input bit lv, input logic [4:0] la, input logic [31:0] ld);
    rst_i = r; alu_valid_i = av; alu_adr_i = aa; alu_data_i = ad;
    lu_valid_i = lv; lu_adr_i = la; lu_data_i = ld;
    @(posedge clk_i);
    @(negedge clk_i);
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    logic [4:0] got[$];
    bit         acc;
    int         li;

    rst_i = 1; alu_valid_i = 0; alu_adr_i = 0; alu_data_i = 0;
    lu_valid_i = 0; lu_adr_i = 0; lu_data_i = 0;
    @(negedge clk_i); #1;
    step(1, 0, 0, 0, 0, 0, 0);
    chk_en = 1;
    step(1, 0, 0, 0, 0, 0, 0);
    chk("rst_ready", {31'd0, lu_ready_o}, 0);

    // idle after reset
    for (int k = 0; k < 5; k++) begin
      idle();
      chk("idle_wadr",  {27'd0, wadr_o}, 0);
      chk("idle_ready", {31'd0, lu_ready_o}, 1);
      chk("idle_count", {29'd0, fifo_count_o}, 0);
    end

    // ALU write then bypass
    step(0, 1, 3, 32'hDEADBEEF, 0, 0, 0);
    chk("alu_wadr",  {27'd0, wadr_o}, 3);
    chk("alu_wdata", wdata_o, 32'hDEADBEEF);
    idle();
    chk("gap_wadr", {27'd0, wadr_o}, 0);
    step(0, 0, 0, 0, 1, 7, 32'h12345678);
    chk("byp_wadr",  {27'd0, wadr_o}, 7);
    chk("byp_wdata", wdata_o, 32'h12345678);
    chk("byp_pend",  pend_mask_o, 0);
    idle();

    // ALU burst fills the FIFO, then drain in order
    li = 0;
    for (int k = 0; k < 8; k++) begin
      acc = (li < 5) && lu_ready_o;
      step(0, 1, 5'(k + 1), 32'h100 + k, li < 5, 5'(10 + li), 32'h200 + 10 + li);
      if (acc) li++;
      chk("burst_wadr", {27'd0, wadr_o}, k + 1);
    end
    chk("full_count", {29'd0, fifo_count_o}, 4);
    chk("full_ready", {31'd0, lu_ready_o}, 0);
    chk("full_pend",  pend_mask_o, 32'h00003C00);
    for (int k = 0; k < 6; k++) begin
      acc = (li < 5) && lu_ready_o;
      step(0, 0, 0, 0, li < 5, 5'(10 + li), 32'h200 + 10 + li);
      if (acc) li++;
      if (wadr_o != 0) got.push_back(wadr_o);
    end
    chk("drain_len", got.size(), 5);
    for (int k = 0; k < 5 && k < got.size(); k++) chk("drain_order", {27'd0, got[k]}, 10 + k);
    chk("drain_empty", {29'd0, fifo_count_o}, 0);

    // WAW kill of a queued entry
    step(0, 1, 1, 32'h11, 1, 5, 32'h1);
    step(0, 1, 2, 32'h22, 1, 6, 32'h2);
    chk("waw_pend0", pend_mask_o, 32'h60);
    step(0, 1, 5, 32'hAA, 0, 0, 0);
    chk("waw_wadr",  {27'd0, wadr_o}, 5);
    chk("waw_wdata", wdata_o, 32'hAA);
    chk("waw_pend1", pend_mask_o, 32'h40);
    idle();
    chk("dead_wadr",  {27'd0, wadr_o}, 0);
    chk("dead_wdata", wdata_o, 0);
    idle();
    chk("live6_wadr",  {27'd0, wadr_o}, 6);
    chk("live6_wdata", wdata_o, 32'h2);

    // same-cycle kill of an incoming long-latency result
    step(0, 1, 9, 32'h99, 1, 9, 32'h55);
    chk("inkill_count", {29'd0, fifo_count_o}, 1);
    chk("inkill_pend",  pend_mask_o, 0);
    idle();
    chk("inkill_wadr", {27'd0, wadr_o}, 0);
    idle();

    // transfer to r0 is swallowed
    step(0, 0, 0, 0, 1, 0, 32'hFFFFFFFF);
    chk("r0_wadr",  {27'd0, wadr_o}, 0);
    chk("r0_wdata", wdata_o, 0);
    chk("r0_count", {29'd0, fifo_count_o}, 0);

    // reset with entries queued
    step(0, 1, 1, 32'h1, 1, 20, 32'h20);
    step(0, 1, 2, 32'h2, 1, 21, 32'h21);
    step(0, 1, 3, 32'h3, 1, 22, 32'h22);
    chk("pre_rst_count", {29'd0, fifo_count_o}, 3);
    chk("pre_rst_pend",  pend_mask_o, 32'h00700000);
    rst_i = 1; alu_valid_i = 0; lu_valid_i = 0;
    #1;
    chk("in_rst_ready", {31'd0, lu_ready_o}, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("rst_count", {29'd0, fifo_count_o}, 0);
    chk("rst_pend",  pend_mask_o, 0);
    chk("rst_wadr",  {27'd0, wadr_o}, 0);
    for (int k = 0; k < 4; k++) begin
      idle();
      chk("post_rst_wadr",  {27'd0, wadr_o}, 0);
      chk("post_rst_ready", {31'd0, lu_ready_o}, 1);
    end

    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
